// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: flag/resume inputs from the datapath side and the
// datapath/RAM control strobes driven by the multicycle FSM.
interface multicycle_control_unit_if;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       resume;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       write_reg_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;

    modport master (
        input  zero_op, neg_op, unsigned_overflow, signed_overflow, resume,
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, ram_write_enable, halt
    );

    modport slave (
        output zero_op, neg_op, unsigned_overflow, signed_overflow, resume,
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, ram_write_enable, halt
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// K-and-S decoded-instruction type plus the multicycle control FSM that
// sequences fetch, decode and execute with a parametrised RAM read latency.
package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module multicycle_control_unit
    import k_and_s_pkg::*;
#(
    parameter int RAM_WAIT = 1,
    parameter int WAIT_W   = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  decoded_instruction_type    decoded_instruction,
    multicycle_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_LATCH_IR, S_DECODE, S_MEM_WAIT, S_LOAD_WB,
        S_STORE_WR, S_EXEC, S_BR, S_HALTED
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WAIT_W-1:0] wcnt_reg;
    logic [WAIT_W-1:0] wcnt_next;
    logic              wait_done;
    logic              taken;
    logic [1:0]        alu_op;
    logic              alu_flags;
    logic              unused_flag;

    assign unused_flag = bus.unsigned_overflow;
    assign wait_done   = (wcnt_reg == WAIT_W'(RAM_WAIT));

    // The flag register only loads in EXEC, so the flags seen in DECODE are
    // the ones BR would see; deciding here lets branch/pc_enable be registered.
    always_comb begin
        taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = bus.zero_op;
            I_BNZERO: taken = !bus.zero_op;
            I_BNEG:   taken = bus.neg_op;
            I_BNNEG:  taken = !bus.neg_op;
            I_BOV:    taken = bus.signed_overflow;
            I_BNOV:   taken = !bus.signed_overflow;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_op    = 2'b00;
        alu_flags = 1'b0;
        case (decoded_instruction)
            I_ADD:   begin alu_op = 2'b01; alu_flags = 1'b1; end
            I_SUB:   begin alu_op = 2'b10; alu_flags = 1'b1; end
            I_AND:   begin alu_op = 2'b11; alu_flags = 1'b1; end
            I_OR:    begin alu_op = 2'b00; alu_flags = 1'b1; end
            default: begin alu_op = 2'b00; alu_flags = 1'b0; end
        endcase
    end

    // The counter is zero outside FETCH/MEM_WAIT and stops at RAM_WAIT, so it
    // always starts from zero on entry and can never wrap.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = '0;
        case (state_reg)
            S_FETCH: begin
                if (wait_done) state_next = S_LATCH_IR;
                else           wcnt_next  = wcnt_reg + 1'b1;
            end
            S_LATCH_IR: state_next = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:  state_next = S_MEM_WAIT;
                    I_STORE: state_next = S_STORE_WR;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                             state_next = S_EXEC;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                             state_next = S_BR;
                    I_HALT:  state_next = S_HALTED;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEM_WAIT: begin
                if (wait_done) state_next = S_LOAD_WB;
                else           wcnt_next  = wcnt_reg + 1'b1;
            end
            S_LOAD_WB, S_STORE_WR, S_EXEC, S_BR: state_next = S_FETCH;
            S_HALTED: state_next = bus.resume ? S_FETCH : S_HALTED;
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state they belong to and reset forces every strobe low immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg            <= S_FETCH;
            wcnt_reg             <= '0;
            bus.branch           <= 1'b0;
            bus.pc_enable        <= 1'b0;
            bus.ir_enable        <= 1'b0;
            bus.write_reg_enable <= 1'b0;
            bus.addr_sel         <= 1'b0;
            bus.c_sel            <= 1'b0;
            bus.operation        <= 2'b00;
            bus.flags_reg_enable <= 1'b0;
            bus.ram_write_enable <= 1'b0;
            bus.halt             <= 1'b0;
        end else begin
            state_reg            <= state_next;
            wcnt_reg             <= wcnt_next;
            bus.branch           <= 1'b0;
            bus.pc_enable        <= 1'b0;
            bus.ir_enable        <= 1'b0;
            bus.write_reg_enable <= 1'b0;
            bus.addr_sel         <= 1'b0;
            bus.c_sel            <= 1'b0;
            bus.operation        <= 2'b00;
            bus.flags_reg_enable <= 1'b0;
            bus.ram_write_enable <= 1'b0;
            bus.halt             <= 1'b0;
            case (state_next)
                S_LATCH_IR: begin
                    bus.ir_enable <= 1'b1;
                    bus.pc_enable <= 1'b1;
                end
                S_MEM_WAIT: bus.addr_sel <= 1'b1;
                S_LOAD_WB: begin
                    bus.addr_sel         <= 1'b1;
                    bus.write_reg_enable <= 1'b1;
                end
                S_STORE_WR: begin
                    bus.addr_sel         <= 1'b1;
                    bus.ram_write_enable <= 1'b1;
                end
                S_EXEC: begin
                    bus.c_sel            <= 1'b1;
                    bus.write_reg_enable <= 1'b1;
                    bus.operation        <= alu_op;
                    bus.flags_reg_enable <= alu_flags;
                end
                S_BR: begin
                    bus.branch    <= taken;
                    bus.pc_enable <= taken;
                end
                S_HALTED: bus.halt <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized and directed bench for multicycle_control_unit at RAM_WAIT 0, 1
// and 3, checking per-cycle output traces from a per-instruction timing model.
module tb_multicycle_control_unit;
    import k_and_s_pkg::*;

    localparam int N = 3;

    // Output vector: {branch, pc_en, ir_en, wr_en, addr_sel, c_sel, op[1:0], fl_en, ram_we, halt}
    localparam logic [10:0] O_BR  = 11'h400;
    localparam logic [10:0] O_PC  = 11'h200;
    localparam logic [10:0] O_IR  = 11'h100;
    localparam logic [10:0] O_WR  = 11'h080;
    localparam logic [10:0] O_AS  = 11'h040;
    localparam logic [10:0] O_CS  = 11'h020;
    localparam logic [10:0] O_FL  = 11'h004;
    localparam logic [10:0] O_RW  = 11'h002;
    localparam logic [10:0] O_HLT = 11'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n_arr [N];
    decoded_instruction_type instr_arr [N];
    logic                    zf [N];
    logic                    nf [N];
    logic                    vf [N];
    logic                    cf [N];
    logic                    res [N];
    logic [10:0]             obs [N];

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [10:0] exp_q[$];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
        multicycle_control_unit_if bus ();
        assign bus.zero_op           = zf[gi];
        assign bus.neg_op            = nf[gi];
        assign bus.signed_overflow   = vf[gi];
        assign bus.unsigned_overflow = cf[gi];
        assign bus.resume            = res[gi];
        assign obs[gi] = {bus.branch, bus.pc_enable, bus.ir_enable, bus.write_reg_enable,
                          bus.addr_sel, bus.c_sel, bus.operation, bus.flags_reg_enable,
                          bus.ram_write_enable, bus.halt};
        multicycle_control_unit #(.RAM_WAIT(W)) dut (
            .clk                 (clk),
            .rst_n               (rst_n_arr[gi]),
            .decoded_instruction (instr_arr[gi]),
            .bus                 (bus)
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    // Expected per-cycle outputs of one instruction, starting at its first
    // FETCH cycle; HALT assumes resume is already high (one halted cycle).
    function automatic void model_trace(input int w, input decoded_instruction_type ins,
                                        input logic z, input logic n, input logic v);
        logic tk;
        exp_q.delete();
        for (int i = 0; i <= w; i++) exp_q.push_back(11'h000);
        exp_q.push_back(O_IR | O_PC);
        exp_q.push_back(11'h000);
        tk = 1'b0;
        case (ins)
            I_BRANCH: tk = 1'b1;
            I_BZERO:  tk = z;
            I_BNZERO: tk = !z;
            I_BNEG:   tk = n;
            I_BNNEG:  tk = !n;
            I_BOV:    tk = v;
            I_BNOV:   tk = !v;
            default:  tk = 1'b0;
        endcase
        case (ins)
            I_LOAD: begin
                for (int i = 0; i <= w; i++) exp_q.push_back(O_AS);
                exp_q.push_back(O_AS | O_WR);
            end
            I_STORE: exp_q.push_back(O_AS | O_RW);
            I_MOVE:  exp_q.push_back(O_CS | O_WR);
            I_ADD:   exp_q.push_back(O_CS | O_WR | O_FL | (11'd1 << 3));
            I_SUB:   exp_q.push_back(O_CS | O_WR | O_FL | (11'd2 << 3));
            I_AND:   exp_q.push_back(O_CS | O_WR | O_FL | (11'd3 << 3));
            I_OR:    exp_q.push_back(O_CS | O_WR | O_FL);
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                     exp_q.push_back(tk ? (O_BR | O_PC) : 11'h000);
            I_HALT:  exp_q.push_back(O_HLT);
            default: ;
        endcase
    endfunction

    task automatic sync_reset(input int k);
        rst_n_arr[k] = 1'b0;
        @(posedge clk); #1;
        check_cnt++;
        if (obs[k] !== 11'h000) $display("FAIL sync_reset dut%0d: got %h want 000", k, obs[k]);
        else pass_cnt++;
        rst_n_arr[k] = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) rst_n_arr[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                check_cnt++;
                if (obs[k] !== 11'h000)
                    $display("FAIL reset dut%0d cyc%0d: got %h want 000", k, c, obs[k]);
                else pass_cnt++;
            end
        end
        for (int k = 0; k < N; k++) rst_n_arr[k] = 1'b1;
        $display("reset: all outputs checked low for 3 cycles");
    endtask

    task automatic test_add_w1();
        sync_reset(1);
        instr_arr[1] = I_ADD;
        model_trace(1, I_ADD, 1'b0, 1'b0, 1'b0);
        foreach (exp_q[i]) begin
            check_cnt++;
            if (obs[1] !== exp_q[i]) $display("FAIL add_w1 cyc%0d: got %h want %h", i + 1, obs[1], exp_q[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        check_cnt++;
        if (obs[1] !== 11'h000) $display("FAIL add_w1 next_fetch: got %h want 000", obs[1]);
        else pass_cnt++;
        $display("add_w1: %0d-cycle trace", exp_q.size());
    endtask

    task automatic test_load_w3();
        int as_cnt = 0;
        int wr_cnt = 0;
        int wr_cyc = -1;
        sync_reset(2);
        instr_arr[2] = I_LOAD;
        model_trace(3, I_LOAD, 1'b0, 1'b0, 1'b0);
        foreach (exp_q[i]) begin
            check_cnt++;
            if (obs[2] !== exp_q[i]) $display("FAIL load_w3 cyc%0d: got %h want %h", i + 1, obs[2], exp_q[i]);
            else pass_cnt++;
            if (obs[2][6]) as_cnt++;
            if (obs[2][7] && !obs[2][5]) begin wr_cnt++; wr_cyc = i + 1; end
            @(posedge clk); #1;
        end
        check_cnt++;
        if (as_cnt !== 5) $display("FAIL load_w3 addr_sel_cycles: got %0d want 5", as_cnt);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt !== 1 || wr_cyc !== 11)
            $display("FAIL load_w3 wb: got %0d pulses at cyc%0d want 1 at cyc11", wr_cnt, wr_cyc);
        else pass_cnt++;
        $display("load_w3: addr_sel %0d cycles, write at cycle %0d", as_cnt, wr_cyc);
    endtask

    task automatic test_store_move_w0();
        decoded_instruction_type seq [2];
        seq[0] = I_STORE;
        seq[1] = I_MOVE;
        sync_reset(0);
        for (int s = 0; s < 2; s++) begin
            instr_arr[0] = seq[s];
            model_trace(0, seq[s], 1'b0, 1'b0, 1'b0);
            foreach (exp_q[i]) begin
                check_cnt++;
                if (obs[0] !== exp_q[i])
                    $display("FAIL store_move_w0 %s cyc%0d: got %h want %h", seq[s].name(), i + 1, obs[0], exp_q[i]);
                else pass_cnt++;
                @(posedge clk); #1;
            end
            $display("store_move_w0: %s %0d cycles", seq[s].name(), exp_q.size());
        end
    endtask

    task automatic test_branch();
        logic [2:0] fl;
        decoded_instruction_type ins;
        sync_reset(1);
        for (int t = 0; t < 9; t++) begin
            ins = (t < 2) ? I_BZERO : decoded_instruction_type'(5'(8 + $urandom_range(0, 6)));
            fl  = 3'($urandom_range(0, 7));
            if (t == 0) fl = 3'b001;
            if (t == 1) fl = 3'b000;
            instr_arr[1] = ins;
            zf[1] = fl[0];
            nf[1] = fl[1];
            vf[1] = fl[2];
            model_trace(1, ins, fl[0], fl[1], fl[2]);
            foreach (exp_q[i]) begin
                check_cnt++;
                if (obs[1] !== exp_q[i])
                    $display("FAIL branch %s z%0d n%0d v%0d cyc%0d: got %h want %h",
                             ins.name(), fl[0], fl[1], fl[2], i + 1, obs[1], exp_q[i]);
                else pass_cnt++;
                @(posedge clk); #1;
            end
            $display("branch: %s flags z%0d n%0d v%0d", ins.name(), fl[0], fl[1], fl[2]);
        end
        zf[1] = 1'b0; nf[1] = 1'b0; vf[1] = 1'b0;
    endtask

    task automatic test_halt();
        sync_reset(1);
        res[1] = 1'b0;
        instr_arr[1] = I_HALT;
        model_trace(1, I_HALT, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) exp_q.push_back(O_HLT);
        foreach (exp_q[i]) begin
            check_cnt++;
            if (obs[1] !== exp_q[i]) $display("FAIL halt_hold cyc%0d: got %h want %h", i + 1, obs[1], exp_q[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        res[1] = 1'b1;
        check_cnt++;
        if (obs[1] !== O_HLT) $display("FAIL halt_resume_cycle: got %h want %h", obs[1], O_HLT);
        else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if (obs[1] !== 11'h000) $display("FAIL halt_resumed: got %h want 000", obs[1]);
        else pass_cnt++;
        $display("halt: 20 halted cycles then resume");
        // resume held high through two back-to-back HALTs: one halted cycle each
        for (int r = 0; r < 2; r++) begin
            model_trace(1, I_HALT, 1'b0, 1'b0, 1'b0);
            foreach (exp_q[i]) begin
                check_cnt++;
                if (obs[1] !== exp_q[i]) $display("FAIL halt_resume_high r%0d cyc%0d: got %h want %h", r, i + 1, obs[1], exp_q[i]);
                else pass_cnt++;
                @(posedge clk); #1;
            end
            $display("halt: resume held high, HALT #%0d", r);
        end
        res[1] = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        sync_reset(2);
        instr_arr[2] = I_LOAD;
        model_trace(3, I_LOAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (obs[2] !== exp_q[i]) $display("FAIL mid_load cyc%0d: got %h want %h", i + 1, obs[2], exp_q[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        sync_reset(2);
        instr_arr[2] = I_ADD;
        model_trace(3, I_ADD, 1'b0, 1'b0, 1'b0);
        foreach (exp_q[i]) begin
            check_cnt++;
            if (obs[2] !== exp_q[i]) $display("FAIL mid_load_restart cyc%0d: got %h want %h", i + 1, obs[2], exp_q[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        $display("reset_mid_load: aborted in MEM_WAIT, restarted with ADD");
    endtask

    task automatic test_random();
        decoded_instruction_type ins;
        logic [3:0] fl;
        for (int k = 0; k < N; k++) begin
            sync_reset(k);
            for (int t = 0; t < 30; t++) begin
                ins = decoded_instruction_type'(5'($urandom_range(0, 31)));
                fl  = 4'($urandom_range(0, 15));
                instr_arr[k] = ins;
                zf[k] = fl[0];
                nf[k] = fl[1];
                vf[k] = fl[2];
                cf[k] = fl[3];
                res[k] = (ins == I_HALT) ? 1'b1 : 1'($urandom_range(0, 1));
                model_trace(wait_of(k), ins, fl[0], fl[1], fl[2]);
                foreach (exp_q[i]) begin
                    check_cnt++;
                    if (obs[k] !== exp_q[i])
                        $display("FAIL random dut%0d t%0d ins%0d cyc%0d: got %h want %h",
                                 k, t, ins, i + 1, obs[k], exp_q[i]);
                    else pass_cnt++;
                    @(posedge clk); #1;
                end
                $display("random: dut%0d t%0d ins=%0d flags=%h %0d cycles", k, t, ins, fl, exp_q.size());
            end
            res[k] = 1'b0;
            instr_arr[k] = I_NOP;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_n_arr[k] = 1'b0;
            instr_arr[k] = I_NOP;
            zf[k] = 1'b0; nf[k] = 1'b0; vf[k] = 1'b0; cf[k] = 1'b0;
            res[k] = 1'b0;
        end
        test_reset();
        test_add_w1();
        test_load_w3();
        test_store_move_w0();
        test_branch();
        test_halt();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
